// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 1-bit mux among four requesters.
// Grants are bounded by HOLD_MAX cycles; a release re-arbitrates in the same edge.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       valid,
  output logic       out
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;

  logic [1:0] base;
  logic [1:0] win;
  logic       found;
  logic       release_now;

  // On release the search starts just past the old owner, which equals the updated pointer.
  assign base        = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
  assign release_now = (state_q == GRANT) && (!req[sel_q] || (cnt_q == 4'(HOLD_MAX)));

  always_comb begin
    found = 1'b0;
    win   = base;
    for (int k = 3; k >= 0; k--) begin
      if (req[base + 2'(k)]) begin
        found = 1'b1;
        win   = base + 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          grant_d = 4'b0001 << win;
          valid_d = 1'b1;
          cnt_d   = 4'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = sel_q + 2'd1;
          if (found) begin
            sel_d   = win;
            grant_d = 4'b0001 << win;
            cnt_d   = 4'd1;
          end else begin
            state_d = IDLE;
            grant_d = 4'b0000;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign out   = valid_q ? in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: two instances (HOLD_MAX=4 and HOLD_MAX=1)
// share stimulus and are compared every cycle against a behavioural model.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] in;

  logic [3:0] grant4, grant1;
  logic [1:0] sel4, sel1;
  logic       valid4, valid1;
  logic       out4, out1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       out;
  } exp_t;

  exp_t sb[$];

  int holds[2] = '{4, 1};
  int m_busy[2];
  int m_sel[2];
  int m_ptr[2];
  int m_cnt[2];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.HOLD_MAX(4)) u_hold4 (
    .clk(clk), .reset(reset), .req(req), .in(in),
    .grant(grant4), .sel(sel4), .valid(valid4), .out(out4)
  );

  mux_rr_arbiter #(.HOLD_MAX(1)) u_hold1 (
    .clk(clk), .reset(reset), .req(req), .in(in),
    .grant(grant1), .sel(sel1), .valid(valid1), .out(out1)
  );

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model for one edge, queue the expected outputs, then compare after the edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [3:0] d);
    exp_t e;
    int w;
    reset = rst;
    req   = r;
    in    = d;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0;
      end else if (m_busy[k] == 0) begin
        w = pick(r, m_ptr[k]);
        if (w >= 0) begin
          m_busy[k] = 1; m_sel[k] = w; m_cnt[k] = 1;
        end
      end else if (!r[m_sel[k]] || m_cnt[k] == holds[k]) begin
        m_ptr[k] = (m_sel[k] + 1) % 4;
        w = pick(r, m_ptr[k]);
        if (w >= 0) begin
          m_sel[k] = w; m_cnt[k] = 1;
        end else begin
          m_busy[k] = 0;
        end
      end else begin
        m_cnt[k]++;
      end
      e.grant = m_busy[k] ? (4'b0001 << m_sel[k]) : 4'b0000;
      e.sel   = 2'(m_sel[k]);
      e.valid = (m_busy[k] != 0);
      e.out   = m_busy[k] ? d[m_sel[k]] : 1'b0;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    checkOutput("grant_h4", grant4, e.grant);
    checkOutput("sel_h4",   {2'b00, sel4}, {2'b00, e.sel});
    checkOutput("valid_h4", {3'b000, valid4}, {3'b000, e.valid});
    checkOutput("out_h4",   {3'b000, out4}, {3'b000, e.out});
    e = sb.pop_front();
    checkOutput("grant_h1", grant1, e.grant);
    checkOutput("sel_h1",   {2'b00, sel1}, {2'b00, e.sel});
    checkOutput("valid_h1", {3'b000, valid1}, {3'b000, e.valid});
    checkOutput("out_h1",   {3'b000, out1}, {3'b000, e.out});
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    in    = 4'b0000;

    // Reset then idle
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    applyStimulus(1'b1, 4'b0000, 4'b1111);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b0000, 4'b1111);
      checkOutput("idle_grant", grant4, 4'b0000);
      checkOutput("idle_out", {3'b000, out4}, 4'b0000);
    end

    // Single request, then drop
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    checkOutput("single_grant", grant4, 4'b0100);
    checkOutput("single_sel", {2'b00, sel4}, 4'b0010);
    checkOutput("single_out", {3'b000, out4}, 4'b0001);
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    applyStimulus(1'b0, 4'b0000, 4'b0100);
    checkOutput("drop_valid", {3'b000, valid4}, 4'b0000);
    checkOutput("drop_sel", {2'b00, sel4}, 4'b0010);

    // Round robin with every requester active
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0, 4'b1111, 4'(c * 5));
      checkOutput("rr_sel_h4", {2'b00, sel4}, 4'((c / 4) % 4));
      checkOutput("rr_sel_h1", {2'b00, sel1}, 4'(c % 4));
      checkOutput("rr_valid_h4", {3'b000, valid4}, 4'b0001);
    end

    // Priority rotation
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0010, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0011, 4'b0000);
    checkOutput("rot_wrap", grant4, 4'b0001);
    applyStimulus(1'b0, 4'b1000, 4'b0000);
    checkOutput("rot_owner3", grant4, 4'b1000);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1010, 4'b0000);
    checkOutput("rot_after3", grant4, 4'b0010);

    // Two requesters, single-cycle hold alternates
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 4'b0101, (c % 2 == 0) ? 4'b0001 : 4'b0000);
      checkOutput("alt_grant_h1", grant1, (c % 2 == 0) ? 4'b0001 : 4'b0100);
      checkOutput("alt_out_h1", {3'b000, out1}, (c % 2 == 0) ? 4'b0001 : 4'b0000);
    end

    // Reset in the middle of a grant
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    checkOutput("midrst_grant", grant4, 4'b0000);
    checkOutput("midrst_sel", {2'b00, sel4}, 4'b0000);
    applyStimulus(1'b0, 4'b0100, 4'b0100);
    checkOutput("midrst_regrant", grant4, 4'b0100);

    // Random traffic checked against the model only
    for (int c = 0; c < 60; c++) begin
      applyStimulus(($urandom_range(0, 29) == 0), 4'($urandom), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 1-bit mux between four requesters. It samples per-requester requests, grants exactly one owner at a time, and drives the owner's index onto the mux select. It also presents the selected data bit, qualified by a valid flag. Grant length is bounded by a hold limit so no requester can starve the others.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one owner may hold the grant (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  4  request per requester; bit i = requester i
in  input  4  data bit per requester; bit i belongs to requester i
grant  output  4  one-hot grant, registered; all-zero when no owner
sel  output  2  registered mux select = index of current/last owner
valid  output  1  registered; high while an owner holds the grant
out  output  1  combinational: in[sel] when valid=1, else 0

Behaviour:
- Interface (decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset (sampled high at edge):
  - state=IDLE, grant=4'b0000, sel=2'b00, valid=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - Hold counter cnt=0.
  - Reset overrides all other activity, including mid-grant: grant drops at that edge.
- Arbitration function pick(req, ptr):
  - Search the indices ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first index with req bit set wins.
- State IDLE:
  - req==0: stay IDLE; grant=0, valid=0, sel holds its last value.
  - req!=0 at edge N: after edge N, state=GRANT, owner=pick(req,ptr), grant=one-hot(owner), sel=owner, valid=1, cnt=1.
  - Request-to-grant latency is 1 cycle.
- State GRANT, evaluated at each edge:
  - Release when req[owner]==0 is sampled, or when cnt==HOLD_MAX.
  - Otherwise keep the owner and increment cnt. Other requesters' req bits are ignored.
- On release:
  - ptr = owner+1 mod 4, so the old owner gets lowest priority.
  - Arbitration runs in the same edge using the sampled req, the new ptr, and all four bits (the old owner is eligible if still requesting).
  - A winner exists: the new grant takes effect immediately (back-to-back, no idle cycle) and cnt=1.
  - No winner: go to IDLE; grant=0, valid=0, sel unchanged.
- Hold bound:
  - An owner holding req continuously is granted exactly HOLD_MAX cycles.
  - HOLD_MAX=1 rotates the grant every cycle among active requesters.
  - A sole requester with req held high is re-granted after its hold expires, so valid stays continuously high.
- Invariants: grant is always one-hot or zero; valid == |grant; grant[sel]==1 whenever valid.
- Width rules: cnt is 4 bits; ptr and sel increment modulo 4 and wrap 3->0.
- No X on outputs after the first reset edge.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, req=0000 -> grant=0000, sel=00, valid=0, out=0 for 5 cycles.
- Single request: req=0100 at edge N -> after N: grant=0100, sel=10, valid=1; in=0100 gives out=1. Drop req at edge N+2 -> IDLE after N+2, valid=0, sel stays 10.
- Round robin: req=1111 held, HOLD_MAX=4 -> owners 0,1,2,3,0 each for exactly 4 cycles; sel sequence 00,01,10,11,00 with no gaps; valid constantly 1.
- Priority rotation:
  - Owner 1 releases; next cycle req=0011 -> grant=0001 (ptr=2 wraps to 0 before reaching 1).
  - Check that req=1010 after owner 3 releases -> grant=0010.
- HOLD_MAX=1, req=0101 -> grant alternates 0001,0100 every cycle; out tracks in[0], in[2] alternately.
- Reset mid-grant: owner 2 at cnt=2, reset pulsed 1 cycle -> next cycle grant=0000, valid=0, sel=00. With req=0100 still high after reset drops -> grant=0100 one cycle later, cnt restarts at 1.
